ioctl_upload_server: RTL
========================

IOCTL_UPLOAD_SERVER -- requirements
Module: ioctl_upload_server

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: buffer address width, so depth = 2^ADDR_W bytes.
REQ-002 SHALL have parameter UPLOAD_INDEX, default 8'd4: the ioctl_index this block serves.
REQ-003 SHALL have parameter TIMEOUT, default 24'd4000000: the number of clk cycles to wait for the HPS to start an upload.
REQ-004 clk  input  1  system clock; the only clock in the block.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 save_trigger  input  1  single-cycle request to snapshot game RAM and upload it.
REQ-007 ram_rd  output  1  read strobe to game RAM.
REQ-008 ram_addr  output  ADDR_W  game RAM read address.
REQ-009 ram_data  input  8  game RAM read data; valid one cycle after ram_rd.
REQ-010 ioctl_upload  input  1  HPS upload in progress.
REQ-011 ioctl_index  input  8  HPS transfer index.
REQ-012 ioctl_rd  input  1  HPS byte-read strobe.
REQ-013 ioctl_addr  input  25  HPS byte address.
REQ-014 ioctl_din  output  8  byte returned to the HPS.
REQ-015 ioctl_upload_req  output  1  single-cycle request for the HPS to start an upload.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  single-cycle pulse when an upload completes.
REQ-018 timeout_err  output  1  single-cycle pulse when the HPS wait expires.

Function
REQ-019 The FSM SHALL have states IDLE, SNAP, REQ, WAIT_UP, SERVE and FIN.
REQ-020 In IDLE, save_trigger=1 SHALL move the FSM to SNAP and clear the snapshot address counter to 0.
REQ-021 In SNAP, ram_rd SHALL be high and ram_addr SHALL equal the counter, which increments by 1 each cycle.
REQ-022 In SNAP, ram_data SHALL be written into the buffer at address (counter-1) one cycle after each read.
REQ-023 SNAP SHALL last exactly 2^ADDR_W+1 cycles; the last write goes to address 2^ADDR_W-1, and then the FSM moves to REQ.
REQ-024 The counter SHALL be ADDR_W+1 bits wide so the terminal count is detected without wrap-around.
REQ-025 REQ SHALL assert ioctl_upload_req for exactly one cycle and then move to WAIT_UP.
REQ-026 In WAIT_UP, ioctl_upload=1 with ioctl_index==UPLOAD_INDEX SHALL move the FSM to SERVE.
REQ-027 In WAIT_UP, the FSM SHALL return to IDLE and pulse timeout_err after TIMEOUT cycles with no matching upload.
REQ-028 In IDLE, a matching upload that the HPS starts on its own SHALL move the FSM directly to SERVE and serve the existing buffer contents.
REQ-029 In SERVE, each ioctl_rd SHALL read the buffer at ioctl_addr[ADDR_W-1:0].
REQ-030 ioctl_din SHALL update exactly 2 cycles after ioctl_rd and SHALL hold until the next read result.
REQ-031 ioctl_din SHALL be 8'h00 for ioctl_addr >= 2^ADDR_W, with no aliasing.
REQ-032 ioctl_rd on consecutive cycles SHALL be supported at full throughput.
REQ-033 In SERVE, deassertion of ioctl_upload SHALL move the FSM to FIN.
REQ-034 FIN SHALL pulse done for one cycle and then return to IDLE.
REQ-035 save_trigger outside IDLE SHALL be ignored; it is not queued.
REQ-036 Uploads or reads with ioctl_index != UPLOAD_INDEX SHALL be ignored in every state, and ioctl_din SHALL be unchanged.
REQ-037 If save_trigger and a matching ioctl_upload rise in the same IDLE cycle, the upload SHALL take priority and the trigger is dropped.
REQ-038 ram_rd SHALL be low in every state except SNAP.

Reset
REQ-039 Reset SHALL force the FSM to IDLE from any state, mid-SNAP or mid-SERVE included.
REQ-040 During reset, ram_rd, ioctl_upload_req, busy, done and timeout_err SHALL be 0.
REQ-041 During reset, ioctl_din, ram_addr, the snapshot counter and the timeout counter SHALL be 0.
REQ-042 Buffer contents SHALL NOT be cleared by reset.
REQ-043 Every register SHALL be reset asynchronously on the rising edge of reset.

Structure
REQ-044 The state enum and the default UPLOAD_INDEX and TIMEOUT constants SHALL live in shared package ioctl_pkg.
REQ-045 The buffer SHALL be a single sub-module, dpram_8 (a simple dual-port RAM with registered read), inferable as block RAM.
REQ-046 The block SHALL have no combinational path from any input to ioctl_din.

Verification
REQ-047 Game RAM filled with byte = addr[7:0] xor 8'h5A, then save_trigger -> ioctl_upload_req pulses 1026 cycles later; a full upload returns each byte matching its address; done pulses once.
REQ-048 save_trigger pulsed again mid-SNAP -> no restart; ioctl_upload_req pulses exactly once.
REQ-049 No HPS response with TIMEOUT=100 -> timeout_err pulses 100 cycles after ioctl_upload_req; busy=0 on the next cycle.
REQ-050 ioctl_rd at ioctl_addr 1023 then 1024 -> ioctl_din = buffer[1023], then 8'h00.
REQ-051 An upload with index 5 while idle -> state stays IDLE and ioctl_din unchanged; a later upload with index 4 -> the old snapshot is served.
REQ-052 Reset asserted at byte 300 of SERVE -> all outputs 0 immediately; a following save_trigger completes a normal cycle.

Source files
------------

// File: rtl/ioctl_pkg.sv
// ioctl_pkg -- shared definitions for the HPS upload server.
//   state_t               : upload server FSM states
//   DEFAULT_UPLOAD_INDEX  : ioctl_index served unless overridden
//   DEFAULT_TIMEOUT       : clk cycles to wait for the HPS to start an upload
package ioctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    REQ,
    WAIT_UP,
    SERVE,
    FIN
  } state_t;

  localparam logic [7:0]  DEFAULT_UPLOAD_INDEX = 8'd4;
  localparam logic [23:0] DEFAULT_TIMEOUT      = 24'd4000000;

endpackage

// File: rtl/dpram_8.sv
// dpram_8 -- simple dual-port byte RAM, one write port and one registered
// read port, written so that it maps onto a block RAM.
//   clk      : clock
//   reset    : async active-high reset (clears only the read register)
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write byte
//   rd_en    : read strobe; rd_data updates on the following edge
//   rd_addr  : read address
//   rd_data  : registered read byte
module dpram_8 #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [0:(2**ADDR_W)-1];

  // Array contents are deliberately never reset so the last snapshot
  // survives a reset of the surrounding logic.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ioctl_upload_server.sv
// ioctl_upload_server -- snapshots game RAM into a local buffer and serves
// it to the HPS through the ioctl upload interface.
//   clk, reset        : clock, async active-high reset
//   save_trigger      : one-cycle request to snapshot and upload
//   ram_rd/ram_addr   : read port to game RAM; ram_data arrives a cycle later
//   ioctl_upload/index/rd/addr : HPS upload handshake and byte reads
//   ioctl_din         : byte returned to the HPS, two cycles after ioctl_rd
//   ioctl_upload_req  : one-cycle request for the HPS to start an upload
//   busy              : high whenever the FSM is not idle
//   done, timeout_err : one-cycle completion / HPS-timeout pulses
module ioctl_upload_server
  import ioctl_pkg::*;
#(
  parameter int          ADDR_W       = 10,
  parameter logic [7:0]  UPLOAD_INDEX = DEFAULT_UPLOAD_INDEX,
  parameter logic [23:0] TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_trigger,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_upload_req,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  // One bit wider than the address so the terminal count (DEPTH) is
  // distinguishable from address 0.
  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_CNT = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_ADR = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [ADDR_W:0]   snap_cnt;
  logic [23:0]       wait_cnt;
  logic              match;
  logic              rd_hit;
  logic              rd_oor;
  logic              rd_pend;
  logic              rd_pend_oor;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        buf_q;

  assign match   = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign rd_hit  = (state == SERVE) && ioctl_rd && (ioctl_index == UPLOAD_INDEX);
  assign rd_oor  = |ioctl_addr[24:ADDR_W];

  // Read data lags the address by one cycle, so each byte lands at the
  // previous counter value; the final cycle (count == DEPTH) writes the
  // last byte at DEPTH-1 via the wrap of the low bits.
  assign wr_en   = (state == SNAP) && (snap_cnt != '0);
  assign wr_addr = snap_cnt[ADDR_W-1:0] - ONE_ADR;

  dpram_8 #(.ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (ram_data),
    .rd_en   (rd_hit),
    .rd_addr (ioctl_addr[ADDR_W-1:0]),
    .rd_data (buf_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      snap_cnt <= (state == SNAP) ? snap_cnt + ONE_CNT : '0;
      wait_cnt <= (state == WAIT_UP) ? wait_cnt + 24'd1 : '0;
    end
  end

  // Second read stage: the RAM output register is the first stage, this
  // one adds the out-of-range zeroing and holds the byte between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend     <= 1'b0;
      rd_pend_oor <= 1'b0;
      ioctl_din   <= 8'h00;
    end else begin
      rd_pend     <= rd_hit;
      rd_pend_oor <= rd_oor;
      if (rd_pend) begin
        ioctl_din <= rd_pend_oor ? 8'h00 : buf_q;
      end
    end
  end

  always_comb begin
    state_nx         = state;
    ram_rd           = 1'b0;
    ram_addr         = '0;
    ioctl_upload_req = 1'b0;
    done             = 1'b0;
    timeout_err      = 1'b0;
    busy             = (state != IDLE);
    case (state)
      IDLE: begin
        // An HPS-initiated upload wins over a simultaneous save request.
        if (match) begin
          state_nx = SERVE;
        end else if (save_trigger) begin
          state_nx = SNAP;
        end
      end
      SNAP: begin
        ram_rd   = 1'b1;
        ram_addr = snap_cnt[ADDR_W-1:0];
        if (snap_cnt == DEPTH) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        ioctl_upload_req = 1'b1;
        state_nx         = WAIT_UP;
      end
      WAIT_UP: begin
        if (match) begin
          state_nx = SERVE;
        end else if (wait_cnt == TIMEOUT - 24'd1) begin
          timeout_err = 1'b1;
          state_nx    = IDLE;
        end
      end
      SERVE: begin
        if (!ioctl_upload) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
